// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path: word geometry and the
// responder FSM state encoding.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int OFS_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous write, registered
// synchronous read, no reset so it maps onto block RAM.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port and registered read port; rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, programmable wait states,
// access on an internal word array, response held until the CPU takes it.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [WORD_W-1:0] req_adr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              wr_reg;
    logic [WORD_W-1:0] adr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic              load_ok_reg;
    logic              err_reg;

    logic              accept;
    logic              access;
    logic              acc_wr;
    logic [WORD_W-1:0] acc_adr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_err;
    logic [AW-1:0]     acc_word;
    logic [WORD_W-1:0] arr_rdata;

    // With zero wait states the access happens on the accepting edge, so the
    // live request fields are used; otherwise the captured copy is used.
    assign acc_wr    = (state_reg == IDLE) ? req_wr    : wr_reg;
    assign acc_adr   = (state_reg == IDLE) ? req_adr   : adr_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_err   = (acc_adr[OFS_W-1:0] != '0) ||
                       ({2'b00, acc_adr[WORD_W-1:OFS_W]} >= 32'(DEPTH_WORDS));
    assign acc_word  = acc_adr[AW+OFS_W-1:OFS_W];

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (access && acc_wr && !acc_err),
        .waddr (acc_word),
        .wdata (acc_wdata),
        .re    (access && !acc_wr && !acc_err),
        .raddr (acc_word),
        .rdata (arr_rdata)
    );

    // Stores, errors and the idle/reset case all return zero data.
    assign rsp_rdata = load_ok_reg ? arr_rdata : '0;
    assign rsp_err   = err_reg;

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, captured request and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            wr_reg      <= 1'b0;
            adr_reg     <= '0;
            wdata_reg   <= '0;
            load_ok_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wr_reg    <= req_wr;
                adr_reg   <= req_adr;
                wdata_reg <= req_wdata;
            end
            if (access) begin
                err_reg     <= acc_err;
                load_ok_reg <= !acc_wr && !acc_err;
            end else if (state_reg == RESP && rsp_ready) begin
                err_reg     <= 1'b0;
                load_ok_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states),
// randomized requests against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          chk_data;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [31:0] req_adr   [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rdy_mode [2];
    exp_t        exp_q [2][$];
    logic [31:0] ref_mem   [2][DEPTH];
    bit          ref_known [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
        end
    endtask

    // Reference model: flat word array, error if misaligned or past the end.
    function automatic exp_t model(input int i, input logic wr, input logic [31:0] adr, input logic [31:0] wd);
        exp_t        e;
        int unsigned w;
        w          = adr >> 2;
        e.err      = ((adr & 32'd3) != 0) || (w >= DEPTH);
        e.rdata    = 32'd0;
        e.chk_data = 1'b1;
        e.acc      = 0;
        if (!e.err) begin
            if (wr) begin
                ref_mem[i][w]   = wd;
                ref_known[i][w] = 1'b1;
            end else begin
                e.rdata    = ref_mem[i][w];
                e.chk_data = ref_known[i][w];
            end
        end
        return e;
    endfunction

    // DUTs and per-instance response monitors.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 2 : 0;

        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (W)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_wr    (req_wr[gi]),
            .req_adr   (req_adr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .rsp_err   (rsp_err[gi])
        );

        bit          in_rsp = 1'b0;
        exp_t        cur;
        logic [31:0] held_rdata;
        logic        held_err;

        always @(negedge clk) begin
            if (!rst_n) begin
                in_rsp = 1'b0;
            end else if (rsp_valid[gi] === 1'b1) begin
                if (!in_rsp) begin
                    if (exp_q[gi].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rsp inst%0d: got rsp_valid=1 expected no response", gi);
                    end else begin
                        cur = exp_q[gi].pop_front();
                        check("latency", gi, 32'(cyc - cur.acc), 32'(1 + W));
                        check("rsp_err", gi, 32'(rsp_err[gi]), 32'(cur.err));
                        if (cur.chk_data)
                            check("rsp_rdata", gi, rsp_rdata[gi], cur.rdata);
                    end
                    held_rdata = rsp_rdata[gi];
                    held_err   = rsp_err[gi];
                    in_rsp     = 1'b1;
                end else begin
                    check("stable_rdata", gi, rsp_rdata[gi], held_rdata);
                    check("stable_err", gi, 32'(rsp_err[gi]), 32'(held_err));
                end
                check("req_ready_in_resp", gi, 32'(req_ready[gi]), 32'd0);
                if (rsp_ready[gi] === 1'b1) in_rsp = 1'b0;
            end
        end
    end

    // Backpressure driver: 0 = always ready, 1 = random, 2 = never ready.
    initial begin
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                rsp_ready[i] = (rdy_mode[i] == 0) ? 1'b1 :
                               (rdy_mode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Present a request and hold it until accepted; push the expected response.
    task automatic issue(input int i, input bit wr, input logic [31:0] adr, input logic [31:0] wd,
                         input bit vary, output int acc);
        bit   done  = 1'b0;
        int   guard = 0;
        exp_t e;
        acc          = -1;
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_adr[i]   = adr;
        req_wdata[i] = wd;
        while (!done && guard < 200) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) begin
                done  = 1'b1;
                acc   = cyc;
                e     = model(i, req_wr[i], req_adr[i], req_wdata[i]);
                e.acc = cyc;
                exp_q[i].push_back(e);
            end
            @(posedge clk);
            #1;
            if (!done && vary) req_adr[i] = 32'($urandom_range(0, 63)) << 2;
            guard++;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL accept_timeout inst%0d: got no req_ready in 200 cycles expected acceptance", i);
        end
        $display("inst%0d req %s adr=%h wdata=%h accepted@%0d", i, wr ? "ST" : "LD", req_adr[i], req_wdata[i], acc);
        req_valid[i] = 1'b0;
        req_wr[i]    = 1'($urandom_range(0, 1));
        req_adr[i]   = $urandom;
        req_wdata[i] = $urandom;
    endtask

    task automatic wait_idle(input int i);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((exp_q[i].size() != 0 || rsp_valid[i] === 1'b1) && guard < 300);
        n_cmp++;
        if (guard >= 300) begin
            n_bad++;
            $display("FAIL idle_timeout inst%0d: got pending responses after 300 cycles expected drained", i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_req_ready"}, i, 32'(req_ready[i]), 32'd1);
            check({tag, "_rsp_valid"}, i, 32'(rsp_valid[i]), 32'd0);
            check({tag, "_rsp_rdata"}, i, rsp_rdata[i], 32'd0);
            check({tag, "_rsp_err"}, i, 32'(rsp_err[i]), 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_adr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom | 32'h8000_0000;
        if (r == 1) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (r == 2) return 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
        if (r == 3) return 32'((DEPTH - 1) * 4);
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    task automatic random_phase(input int i, input int n);
        int a;
        rdy_mode[i] = 1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(i, 1'($urandom_range(0, 1)), rand_adr(), $urandom, 1'b0, a);
        end
        wait_idle(i);
        rdy_mode[i] = 0;
    endtask

    initial begin
        int a, a1, a2;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_adr[i]   = '0;
            req_wdata[i] = '0;
            rdy_mode[i]  = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load at 0x10 with two wait states.
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, a);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, a);
        wait_idle(0);

        // Errored accesses must not disturb words 0..3.
        for (int k = 0; k < 4; k++) issue(0, 1'b1, 32'(k * 4), $urandom, 1'b0, a);
        issue(0, 1'b0, 32'h13, 32'h0, 1'b0, a);
        issue(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b0, a);
        for (int k = 0; k < 4; k++) issue(0, 1'b0, 32'(k * 4), 32'h0, 1'b0, a);
        wait_idle(0);

        // Last word with the response held off for 5 cycles.
        issue(0, 1'b1, 32'h0FFC, 32'hC0DE_0FFC, 1'b0, a);
        wait_idle(0);
        rdy_mode[0] = 2;
        issue(0, 1'b0, 32'h0FFC, 32'h0, 1'b0, a);
        begin
            int guard = 0;
            while (rsp_valid[0] !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            n_cmp++;
            if (guard >= 50) begin
                n_bad++;
                $display("FAIL rsp_timeout inst0: got rsp_valid=0 expected 1");
            end
        end
        repeat (5) @(negedge clk);
        rdy_mode[0] = 0;
        wait_idle(0);

        // Request held through RESP with a changing address.
        rdy_mode[0] = 1;
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, a);
        issue(0, 1'b0, 32'h20, 32'h0, 1'b1, a);
        wait_idle(0);
        rdy_mode[0] = 0;

        // Reset while a store is still waiting must not commit it.
        issue(0, 1'b1, 32'h20, 32'hAAAA_AAAA, 1'b0, a);
        wait_idle(0);
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, a);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q[0].delete();
        ref_mem[0][8] = 32'hAAAA_AAAA;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h20, 32'h0, 1'b0, a);
        wait_idle(0);

        random_phase(0, 80);

        // Zero wait states: back-to-back stores every 2 cycles.
        issue(1, 1'b1, 32'h0, 32'h1111_0000, 1'b0, a);
        issue(1, 1'b1, 32'h4, 32'h2222_0004, 1'b0, a1);
        issue(1, 1'b1, 32'h8, 32'h3333_0008, 1'b0, a2);
        check("throughput_1", 1, 32'(a1 - a), 32'd2);
        check("throughput_2", 1, 32'(a2 - a1), 32'd2);
        for (int k = 0; k < 3; k++) issue(1, 1'b0, 32'(k * 4), 32'h0, 1'b0, a);
        wait_idle(1);

        random_phase(1, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
